// File: rtl/dnn_pool_pkg.sv
// Shared definitions for the pooling stages: window state encoding and
// counter sizing helpers evaluated at elaboration time.
package dnn_pool_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } pool_state_e;

    function automatic int clog2(input int value);
        int res;
        res = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 << i) < value) begin
                res = i + 1;
            end
        end
        return res;
    endfunction

    // One extra bit so a count equal to POOL_SIZE is representable.
    function automatic int pool_cnt_w(input int pool_size);
        return clog2(pool_size) + 1;
    endfunction

endpackage

// File: rtl/pool_max2.sv
// Combinational signed two-input maximum; on a tie the held operand wins.
module pool_max2 #(
    parameter int W = 16
) (
    input  logic signed [W-1:0] held,
    input  logic signed [W-1:0] cand,
    output logic signed [W-1:0] max_out
);

    assign max_out = (cand > held) ? cand : held;

endmodule

// File: rtl/max_pool_stream.sv
// 1-D streaming max-pool with valid/ready on both sides and registered output.
// Optional averaging mode is compiled in with `define MAX_POOL_AVG_EN.
module max_pool_stream
    import dnn_pool_pkg::*;
#(
    parameter int OP_WIDTH  = 16,
    parameter int POOL_SIZE = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
`ifdef MAX_POOL_AVG_EN
    input  logic                       avg_mode,
`endif
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic signed [OP_WIDTH-1:0] in_data,
    input  logic                       in_last,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic signed [OP_WIDTH-1:0] out_data,
    output logic                       out_last
);

    localparam int CNT_W = pool_cnt_w(POOL_SIZE);
    localparam logic [CNT_W-1:0] FULL_LEN = CNT_W'(POOL_SIZE);
    localparam logic [CNT_W-1:0] ONE_LEN  = CNT_W'(1);

    pool_state_e                state_r;
    logic [CNT_W-1:0]           count_r;
    logic signed [OP_WIDTH-1:0] max_r;
    logic                       pool_en_r;
    logic                       out_valid_r;
    logic signed [OP_WIDTH-1:0] out_data_r;
    logic                       out_last_r;

    logic                       start_s;
    logic                       accept_s;
    logic                       close_s;
    logic [CNT_W-1:0]           cnt_next_s;
    logic [CNT_W-1:0]           win_len_s;
    logic signed [OP_WIDTH-1:0] max_cmp_s;
    logic signed [OP_WIDTH-1:0] max_next_s;
    logic signed [OP_WIDTH-1:0] result_s;

`ifdef MAX_POOL_AVG_EN
    localparam int SHIFT = clog2(POOL_SIZE);
    localparam int SUM_W = OP_WIDTH + SHIFT;

    logic                    avg_mode_r;
    logic signed [SUM_W-1:0] sum_r;
    logic signed [SUM_W-1:0] sum_next_s;
    logic signed [SUM_W-1:0] avg_shift_s;
    logic                    avg_now_s;
`endif

    assign in_ready  = !out_valid_r | out_ready;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_last  = out_last_r;

    pool_max2 #(.W(OP_WIDTH)) u_max2 (
        .held    (max_r),
        .cand    (in_data),
        .max_out (max_cmp_s)
    );

    // Next-window arithmetic for the sample currently offered upstream.
    always_comb begin
        start_s    = (state_r == IDLE);
        accept_s   = in_valid & in_ready;
        cnt_next_s = ONE_LEN;
        win_len_s  = ONE_LEN;
        max_next_s = in_data;
        if (start_s) begin
            cnt_next_s = ONE_LEN;
            win_len_s  = enable ? FULL_LEN : ONE_LEN;
            max_next_s = in_data;
        end else begin
            cnt_next_s = count_r + ONE_LEN;
            win_len_s  = pool_en_r ? FULL_LEN : ONE_LEN;
            max_next_s = max_cmp_s;
        end
        close_s  = accept_s & ((cnt_next_s == win_len_s) | in_last);
        result_s = max_next_s;
`ifdef MAX_POOL_AVG_EN
        // Averaging only applies when pooling is on; pass-through stays exact.
        if (start_s) begin
            sum_next_s = SUM_W'(in_data);
            avg_now_s  = enable & avg_mode;
        end else begin
            sum_next_s = sum_r + SUM_W'(in_data);
            avg_now_s  = pool_en_r & avg_mode_r;
        end
        avg_shift_s = sum_next_s >>> SHIFT;
        if (avg_now_s) begin
            result_s = avg_shift_s[OP_WIDTH-1:0];
        end else begin
            result_s = max_next_s;
        end
`endif
    end

    // Window state: mode latch, sample count and running max.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= IDLE;
            count_r   <= '0;
            max_r     <= '0;
            pool_en_r <= 1'b0;
`ifdef MAX_POOL_AVG_EN
            avg_mode_r <= 1'b0;
            sum_r      <= '0;
`endif
        end else if (accept_s) begin
            if (start_s) begin
                pool_en_r <= enable;
`ifdef MAX_POOL_AVG_EN
                avg_mode_r <= avg_mode;
`endif
            end
            max_r <= max_next_s;
`ifdef MAX_POOL_AVG_EN
            sum_r <= sum_next_s;
`endif
            if (close_s) begin
                state_r <= IDLE;
                count_r <= '0;
            end else begin
                state_r <= ACCUM;
                count_r <= cnt_next_s;
            end
        end
    end

    // Output register: reload on window close, otherwise drain on handshake.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_last_r  <= 1'b0;
        end else if (close_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= result_s;
            out_last_r  <= in_last;
        end else if (out_valid_r && out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

endmodule

// File: doc/max_pool_stream.md
Name: max_pool_stream

Overview:
- 1-D streaming max-pool stage. Sits directly downstream of the activation stage and consumes its signed OP_WIDTH samples.
- Reduces each non-overlapping window of POOL_SIZE consecutive samples to one output (stride = POOL_SIZE).
- Valid/ready handshake on both sides, registered output.
- A frame-end marker flushes any partial window.

Parameters:
- OP_WIDTH, 16: signed sample width in bits.
- POOL_SIZE, 4: window length in samples. Legal range 1..256, must be a power of two. POOL_SIZE=1 is a registered pass-through.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (asserted at 0). Deassertion is synchronised externally.
- enable  in  1  1 = pool over POOL_SIZE samples; 0 = pass each sample through (window length 1). Sampled only at window start.
- in_valid  in  1  upstream sample valid.
- in_ready  out  1  this block accepts a sample when in_valid & in_ready.
- in_data  in  OP_WIDTH  signed sample from the activation stage.
- in_last  in  1  last sample of the frame; qualified by the input handshake.
- out_valid  out  1  pooled result valid.
- out_ready  in  1  downstream accepts when out_valid & out_ready.
- out_data  out  OP_WIDTH  signed pooled result.
- out_last  out  1  result closes a frame.

Behaviour:
- Reset values:
  - out_valid=0, out_data=0, out_last=0.
  - Window counter=0, running max=0, latched mode=enable-off, state=IDLE.
- in_ready = !out_valid | out_ready, combinational. No bubble when downstream is always ready.
- States:
  - IDLE (count=0, no partial window).
  - ACCUM (partial window held).
- Accepted sample in IDLE:
  - Latch mode: win_len = enable ? POOL_SIZE : 1.
  - max <= in_data, count <= 1.
- Accepted sample in ACCUM:
  - max <= signed max(max, in_data), count <= count+1.
- Window close: an accepted sample with (count+1 == win_len) or in_last closes the window.
  - out_data <= final max (including this sample), out_last <= in_last, out_valid <= 1.
  - count <= 0, state <= IDLE.
- Latency: result is visible on the cycle after the closing sample is accepted.
- Output handshake:
  - out_valid clears on out_valid & out_ready unless a new window closes in the same cycle.
  - If a new window closes in that same cycle, the output register reloads and out_valid stays 1.
- Backpressure: while out_valid & !out_ready, in_ready=0 and no state changes. out_data and out_last are held stable.
- Arithmetic:
  - Comparison is two's-complement signed; ties keep the held value.
  - No widening or saturation; out_data is always one of the input samples.
- Counter width is clog2(POOL_SIZE)+1 and must not wrap.
- A change of enable mid-window has no effect until the next IDLE acceptance.
- in_last on the first sample of a window gives a one-sample window (out_data=in_data).
- Reset mid-window discards the partial window and any pending output.

Optional Feature:
- Macro: MAX_POOL_AVG_EN.
- Defined:
  - Adds input avg_mode (1 bit), latched with enable at window start.
  - When avg_mode=1, the block accumulates a sum of width OP_WIDTH+clog2(POOL_SIZE).
  - Full window: out_data = sum >>> clog2(POOL_SIZE) (arithmetic shift, truncation toward -inf).
  - Partial window closed by in_last: the same shift is applied. No division by the actual count.
- Not defined: no avg_mode port, no sum register; max-only behaviour as above.

Decomposition:
- Shared package dnn_pool_pkg holds:
  - state enum {IDLE, ACCUM}.
  - clog2 constant function.
  - POOL_CNT_W derivation helper.
- One natural sub-module: pool_max2, a combinational signed two-input max with tie-keeps-first.
- Everything else stays in max_pool_stream.

Test Plan:
- POOL_SIZE=4, enable=1, samples 3,-7,12,5 (last on 5), out_ready=1 -> one output 12 with out_last=1, one cycle after 5 is accepted.
- All-negative window -8,-2,-15,-3 -> output -2, confirming a signed compare rather than unsigned.
- enable=0, samples 1,-2,3 -> outputs 1,-2,3, each one cycle after acceptance.
- out_ready held 0 for 5 cycles after output 12 -> in_ready=0, out_data stays 12, no samples lost. On release, the next window 9,9,9,9 yields 9.
- in_last on 2nd sample (4, 6) -> output 6 with out_last=1. The next window restarts with count=0.
- Async reset asserted mid-window after 2 samples -> outputs 0 immediately. After release, the fresh window 1,2,3,4 yields 4.
